// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce bank.
//   state_e   : per-channel debounce FSM states
//   *_DEF     : default parameter values for channel count, counter width
//               and synchroniser depth
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_e;

  localparam int CH_DEF   = 4;
  localparam int N_DEF    = 19;
  localparam int SYNC_DEF = 2;

endpackage

// File: rtl/debounce_if.sv
// Channel bundle between the switch side and the debounce bank.
//   in   : raw asynchronous switch levels, one bit per channel
//   out  : debounced levels
//   rise : one-cycle pulse on debounced 0->1
//   fall : one-cycle pulse on debounced 1->0
// master drives the raw inputs; slave is the debouncer.
interface debounce_if #(
  parameter int CH = debounce_pkg::CH_DEF
);
  logic [CH-1:0] in;
  logic [CH-1:0] out;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  modport master (output in, input out, rise, fall);
  modport slave  (input in, output out, rise, fall);
endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: SYNC-stage synchroniser, 4-state FSM with an N-bit
// stability counter, registered level and edge pulses.
//   clk, reset : system clock, synchronous active-high reset
//   din        : raw asynchronous input
//   out        : debounced level (registered)
//   rise, fall : one-cycle pulses on debounced transitions (registered)
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int SYNC = SYNC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [N-1:0] CNT_MAX = '1;

  logic [SYNC-1:0] sync;
  logic            sin;
  state_e          state, state_n;
  logic [N-1:0]    cnt, cnt_n;
  logic            one_n;

  assign sin = sync[SYNC-1];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ZERO:  if (sin) begin state_n = WAIT1; cnt_n = '0; end
      WAIT1: begin
        if (!sin)                state_n = ZERO;
        else if (cnt == CNT_MAX) state_n = ONE;
        else                     cnt_n   = cnt + 1'b1;
      end
      ONE:   if (!sin) begin state_n = WAIT0; cnt_n = '0; end
      WAIT0: begin
        if (sin)                 state_n = ONE;
        else if (cnt == CNT_MAX) state_n = ZERO;
        else                     cnt_n   = cnt + 1'b1;
      end
      default: begin state_n = ZERO; cnt_n = '0; end
    endcase
    // out tracks the side of the FSM we are entering, so it changes on the
    // same edge as the ONE/ZERO transition
    one_n = (state_n == ONE) || (state_n == WAIT0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      state <= ZERO;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC-2:0], din};
      state <= state_n;
      cnt   <= cnt_n;
      out   <= one_n;
      // out holds the current side, so comparing it with the next side
      // gives exactly one cycle of pulse per debounced edge
      rise  <= one_n & ~out;
      fall  <= ~one_n & out;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of CH independent switch debouncers.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : debounce_if slave (in -> out/rise/fall)
// Window is 2^N cycles; input to output latency is SYNC+1+2^N edges.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CH   = CH_DEF,
  parameter int N    = N_DEF,
  parameter int SYNC = SYNC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  debounce_if.slave  bus
);

  logic [CH-1:0] out_v, rise_v, fall_v;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_chan #(.N(N), .SYNC(SYNC)) u_chan (
      .clk   (clk),
      .reset (reset),
      .din   (bus.in[i]),
      .out   (out_v[i]),
      .rise  (rise_v[i]),
      .fall  (fall_v[i])
    );
  end

  assign bus.out  = out_v;
  assign bus.rise = rise_v;
  assign bus.fall = fall_v;

endmodule
